// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FIFO geometry, FSM
// state encoding and a helper for index widths.
package fifo_wr_arb_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned FIFO_ADDR_WIDTH = 8;
  localparam int unsigned FIFO_CAP        = (1 << FIFO_ADDR_WIDTH) - 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Width of an index into n items, at least one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_arb_pick.sv
// Round-robin pick: first set bit of req scanning last+1, last+2, ... (mod NUM_REQ).
// Ports:
//   req  in  NUM_REQ    request vector
//   last in  IDW        previous owner; its successor has highest priority
//   sel  out IDW        chosen requester (valid when any=1)
//   any  out 1          at least one request is set
module rr_arb_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]               req,
  input  logic [id_width(NUM_REQ)-1:0]     last,
  output logic [id_width(NUM_REQ)-1:0]     sel,
  output logic                             any
);

  localparam int unsigned IDW = id_width(NUM_REQ);

  logic [IDW-1:0] idx;

  // Priority scan starting just after the previous owner.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((32'(last) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any = 1'b1;
        sel = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Shares one FIFO write port between NUM_REQ producers with round-robin,
// bounded-burst arbitration. Writes are only issued when the FIFO is certain
// to have room, counting the word still sitting in the output register.
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   req, data_in      producer valid flags and packed words
//   ack               combinational ready; a transfer is req[i] & ack[i]
//   fifo_cnt/full     FIFO occupancy inputs
//   fifo_data/wr_en   registered write to the FIFO
//   grant_id          current/last owner (registered)
//   busy              high while a burst is in progress
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   data_in,
  output logic [NUM_REQ-1:0]              ack,
  input  logic [ADDR_WIDTH-1:0]           fifo_cnt,
  input  logic                            fifo_full,
  output logic [DATA_WIDTH-1:0]           fifo_data,
  output logic                            fifo_wr_en,
  output logic [id_width(NUM_REQ)-1:0]    grant_id,
  output logic                            busy
);

  localparam int unsigned IDW = id_width(NUM_REQ);
  localparam int unsigned BW  = $clog2(MAX_BURST + 1);
  localparam int unsigned CAP = (1 << ADDR_WIDTH) - 1;
  localparam int unsigned CW  = ADDR_WIDTH + 1;

  state_t         state, state_n;
  logic [BW-1:0]  beats, beats_n;
  logic [IDW-1:0] last, last_n;
  logic [IDW-1:0] grant_n;
  logic [NUM_REQ-1:0] ack_c;
  logic           xfer;
  logic [IDW-1:0] pick_sel;
  logic           pick_any;
  logic [CW-1:0]  occ;
  logic           space;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req  (req),
    .last (last),
    .sel  (pick_sel),
    .any  (pick_any)
  );

  // Occupancy including the in-flight word; full can only agree with cnt,
  // so folding it in just guards against a stale count.
  assign occ   = CW'(fifo_cnt) + CW'(fifo_wr_en);
  assign space = (occ < CW'(CAP)) && !fifo_full;

  assign ack  = rst ? ack_c : '0;
  assign busy = (state == ST_BURST);

  // Next-state, ack and beat accounting.
  always_comb begin
    state_n = state;
    beats_n = beats;
    last_n  = last;
    grant_n = grant_id;
    ack_c   = '0;
    xfer    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_any && space) begin
          ack_c[pick_sel] = 1'b1;
          xfer    = 1'b1;
          grant_n = pick_sel;
          beats_n = BW'(1);
          if (MAX_BURST == 1) last_n = pick_sel;
          else                state_n = ST_BURST;
        end
      end
      ST_BURST: begin
        if (req[grant_id]) begin
          // Stalls on a full FIFO hold the burst without consuming a beat.
          if (space) begin
            ack_c[grant_id] = 1'b1;
            xfer    = 1'b1;
            beats_n = beats + BW'(1);
            if (beats_n == BW'(MAX_BURST)) begin
              state_n = ST_IDLE;
              last_n  = grant_id;
            end
          end
        end else begin
          // Owner went quiet: one bubble, then rearbitrate.
          state_n = ST_IDLE;
          last_n  = grant_id;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      beats      <= '0;
      last       <= IDW'(NUM_REQ - 1);
      grant_id   <= '0;
      fifo_wr_en <= 1'b0;
      fifo_data  <= '0;
    end else begin
      state      <= state_n;
      beats      <= beats_n;
      last       <= last_n;
      grant_id   <= grant_n;
      fifo_wr_en <= xfer;
      if (xfer) fifo_data <= words[grant_n];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb in front of a small FIFO model: producer queues,
// expected-ack schedules per scenario and a scoreboard of written words.
module tb_fifo_wr_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] data_in = '0;
  logic [NR-1:0]    ack;
  logic [AW-1:0]    fifo_cnt;
  logic             fifo_full;
  logic [DW-1:0]    fifo_data;
  logic             fifo_wr_en;
  logic [1:0]       grant_id;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q [$];
  logic [7:0] pq [4][$];

  fifo_wr_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .data_in    (data_in),
    .ack        (ack),
    .fifo_cnt   (fifo_cnt),
    .fifo_full  (fifo_full),
    .fifo_data  (fifo_data),
    .fifo_wr_en (fifo_wr_en),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // FIFO model: 255 entries, shares the reset, counts writes it had to drop.
  logic [7:0] mem [256];
  logic [7:0] wp = '0, rp = '0, cnt = '0;
  logic fifo_rd = 1'b0;
  logic preset  = 1'b0;
  int   drops   = 0;
  logic fw, fr;

  assign fifo_cnt  = cnt;
  assign fifo_full = (cnt == 8'd255);
  assign fw = fifo_wr_en && (cnt != 8'd255);
  assign fr = fifo_rd && (cnt != 8'd0);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0; rp <= '0; cnt <= '0;
    end else if (preset) begin
      wp <= 8'd254; rp <= 8'd0; cnt <= 8'd254;
    end else begin
      if (fw) begin
        mem[wp] <= fifo_data;
        wp <= wp + 8'd1;
      end
      if (fifo_wr_en && !fw) drops <= drops + 1;
      if (fr) rp <= rp + 8'd1;
      cnt <= cnt + 8'(fw) - 8'(fr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every registered write must be the next expected word.
  always @(posedge clk) begin
    #1;
    if (rst && fifo_wr_en) begin
      if (exp_q.size() == 0) check("wr_unexpected", 32'(fifo_data), 32'hFFFF_FFFF);
      else                   check("fifo_data", 32'(fifo_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i] = (pq[i].size() != 0);
      data_in[i*8 +: 8] = (pq[i].size() != 0) ? pq[i][0] : 8'h00;
    end
  endtask

  // One cycle: drive at negedge, check ack, push expected word, return at posedge+1.
  task automatic tick(input logic [3:0] exp_ack);
    logic [3:0] hs;
    @(negedge clk);
    drive();
    #1;
    check("ack", 32'(ack), 32'(exp_ack));
    for (int i = 0; i < 4; i++)
      if (exp_ack[i] && pq[i].size() != 0) exp_q.push_back(pq[i][0]);
    hs = req & ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (hs[i] && pq[i].size() != 0) void'(pq[i].pop_front());
  endtask

  initial begin
    logic [3:0] seq3 [9];
    int owner;

    // Power-on reset with all requests high: ack must stay low.
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("por_ack", 32'(ack), 32'h0);
    check("por_wr_en", 32'(fifo_wr_en), 32'h0);
    check("por_data", 32'(fifo_data), 32'h0);
    check("por_grant", 32'(grant_id), 32'h0);
    check("por_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    fifo_rd = 1'b1;

    // Reset mid-burst.
    for (int i = 0; i < 4; i++) begin
      pq[i].push_back(8'(8'h10 + i));
      pq[i].push_back(8'(8'h20 + i));
    end
    tick(4'b0001);
    tick(4'b0001);
    check("burst_busy", 32'(busy), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("rst_data", 32'(fifo_data), 32'h0);
    check("rst_grant", 32'(grant_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    for (int i = 0; i < 4; i++) pq[i].delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fairness: 4-word bursts in order 0,1,2,3,0,...
    for (int i = 0; i < 4; i++)
      for (int s = 0; s < 8; s++) pq[i].push_back(8'(i * 64 + s));
    for (int c = 0; c < 32; c++) begin
      owner = (c / 4) % 4;
      tick(4'(1 << owner));
      if (c % 4 == 0) check("fair_grant", 32'(grant_id), 32'(owner));
    end
    tick(4'b0000);
    tick(4'b0000);

    // Early release: bubble, then req2 gets a fresh 4-beat burst, then req3.
    pq[0].push_back(8'h30); pq[0].push_back(8'h31);
    for (int s = 0; s < 4; s++) pq[2].push_back(8'(8'h50 + s));
    pq[3].push_back(8'h70);
    seq3[0] = 4'b0001; seq3[1] = 4'b0001; seq3[2] = 4'b0000;
    seq3[3] = 4'b0100; seq3[4] = 4'b0100; seq3[5] = 4'b0100; seq3[6] = 4'b0100;
    seq3[7] = 4'b1000; seq3[8] = 4'b0000;
    for (int c = 0; c < 9; c++) begin
      tick(seq3[c]);
      if (c == 2) check("bubble_busy", 32'(busy), 32'h0);
      if (c == 3) check("early_grant", 32'(grant_id), 32'h2);
    end
    tick(4'b0000);
    tick(4'b0000);
    check("drained_cnt", 32'(cnt), 32'h0);

    // Full: no reads, exactly 255 words accepted from req1.
    fifo_rd = 1'b0;
    for (int n = 0; n < 300; n++) pq[1].push_back(8'(n));
    for (int c = 0; c < 260; c++) tick((c < 255) ? 4'b0010 : 4'b0000);
    check("full_cnt", 32'(cnt), 32'd255);
    check("full_flag", 32'(fifo_full), 32'h1);
    check("full_drops", 32'(drops), 32'h0);
    check("full_stall_busy", 32'(busy), 32'h1);
    check("full_left", 32'(pq[1].size()), 32'd45);
    pq[1].delete();
    fifo_rd = 1'b1;
    for (int i = 0; i < 255; i++) begin
      check("readback", 32'(mem[rp]), 32'(i));
      tick(4'b0000);
    end
    check("readback_cnt", 32'(cnt), 32'h0);

    // In-flight: cnt=254, one transfer blocks further acks until a read.
    fifo_rd = 1'b0;
    preset = 1'b1;
    tick(4'b0000);
    preset = 1'b0;
    check("preset_cnt", 32'(cnt), 32'd254);
    pq[0].push_back(8'hC0); pq[0].push_back(8'hC1);
    tick(4'b0001);
    tick(4'b0000);
    tick(4'b0000);
    check("inflight_cnt", 32'(cnt), 32'd255);
    fifo_rd = 1'b1;
    tick(4'b0000);
    fifo_rd = 1'b0;
    check("freed_cnt", 32'(cnt), 32'd254);
    tick(4'b0001);
    tick(4'b0000);
    check("resume_cnt", 32'(cnt), 32'd255);
    check("resume_drops", 32'(drops), 32'h0);
    check("resume_w0", 32'(mem[254]), 32'hC0);
    check("resume_w1", 32'(mem[255]), 32'hC1);

    // Latency: single word from req3.
    fifo_rd = 1'b1;
    repeat (3) tick(4'b0000);
    fifo_rd = 1'b0;
    check("lat_pre_cnt", 32'(cnt), 32'd252);
    pq[3].push_back(8'hA5);
    tick(4'b1000);
    check("lat_wr_en", 32'(fifo_wr_en), 32'h1);
    check("lat_data", 32'(fifo_data), 32'hA5);
    check("lat_cnt_k", 32'(cnt), 32'd252);
    check("lat_grant", 32'(grant_id), 32'h3);
    tick(4'b0000);
    check("lat_cnt_k1", 32'(cnt), 32'd253);
    check("lat_wr_off", 32'(fifo_wr_en), 32'h0);
    tick(4'b0000);
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
